sprite_game_controller: RTL

SPRITE_GAME_CONTROLLER -- requirements
Module: sprite_game_controller

---
 rtl/game_pkg.sv | 55 +++++
 rtl/obstacle_lane.sv | 59 +++++
 rtl/sprite_game_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared FSM state, colours, screen bounds and box helpers
// for the sprite game controller and its obstacle lanes.
package game_pkg;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_HIT,
    ST_OVER
  } state_e;

  localparam logic [11:0] C_BLACK  = 12'h000;
  localparam logic [11:0] C_PLAYER = 12'hF00;
  localparam logic [11:0] C_OBS    = 12'hF0F;
  localparam logic [11:0] C_OVER   = 12'h800;
  localparam logic [11:0] C_RIGHT  = 12'hFF0;
  localparam logic [11:0] C_LEFT   = 12'h0FF;
  localparam logic [11:0] C_DOWN   = 12'h0F0;
  localparam logic [11:0] C_UP     = 12'h00F;
  localparam logic [11:0] C_RESET  = 12'hFFF;

  localparam int DEF_X_MIN = 144;
  localparam int DEF_X_MAX = 783;
  localparam int DEF_Y_MIN = 35;
  localparam int DEF_Y_MAX = 515;

  localparam int P_X0 = 450;
  localparam int P_Y0 = 250;

  // Zero-extend a screen coordinate into signed box arithmetic.
  function automatic logic signed [10:0] s11(
    input logic [9:0] v
  );
    return signed'({1'b0, v});
  endfunction

  // Coordinate c lies inside [ctr-half, ctr+half], inclusive.
  function automatic logic in_box(
    input logic signed [10:0] c,
    input logic signed [10:0] ctr,
    input logic signed [10:0] half
  );
    return (c >= ctr - half) && (c <= ctr + half);
  endfunction

  // Two inclusive spans share at least one pixel.
  function automatic logic span_ovl(
    input logic signed [10:0] a,
    input logic signed [10:0] ha,
    input logic signed [10:0] b,
    input logic signed [10:0] hb
  );
    return (a - ha <= b + hb) && (b - hb <= a + ha);
  endfunction

endpackage

// File: rtl/obstacle_lane.sv
// obstacle_lane: one falling obstacle -- position register, pixel fill
// and overlap against the player box.
module obstacle_lane
  import game_pkg::*;
#(
  parameter int X_POS    = 200,
  parameter int Y_INIT   = 35,
  parameter int OBS_HW   = 60,
  parameter int OBS_HH   = 10,
  parameter int OBS_STEP = 1,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int P_HALF   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] p_x,
  input  logic [9:0] p_y,
  output logic       fill,
  output logic       hit
);

  localparam logic [9:0] Y_RST  = 10'(Y_INIT);
  localparam logic [9:0] Y_LO   = 10'(Y_MIN);
  localparam logic [9:0] Y_HI   = 10'(Y_MAX);
  localparam logic [9:0] Y_STEP = 10'(OBS_STEP);

  localparam logic signed [10:0] S_X  = 11'(X_POS);
  localparam logic signed [10:0] S_HW = 11'(OBS_HW);
  localparam logic signed [10:0] S_HH = 11'(OBS_HH);
  localparam logic signed [10:0] S_PH = 11'(P_HALF);

  logic [9:0] ypos_q, ypos_d;

  // Fall one step per advance, reload at the top once the bottom is hit.
  always_comb begin
    ypos_d = ypos_q;
    if (adv) begin
      if (ypos_q >= Y_HI) ypos_d = Y_LO;
      else                ypos_d = ypos_q + Y_STEP;
    end
  end

  // Obstacle height register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ypos_q <= Y_RST;
    else     ypos_q <= ypos_d;
  end

  assign fill = in_box(s11(h_count), S_X, S_HW)
             && in_box(s11(v_count), s11(ypos_q), S_HH);

  assign hit = span_ovl(s11(p_x), S_PH, S_X, S_HW)
            && span_ovl(s11(p_y), S_PH, s11(ypos_q), S_HH);

endmodule

// File: rtl/sprite_game_controller.sv
// sprite_game_controller: player sprite, falling obstacles, lives FSM, pixel colour.
// Optional WRAP_EN: player wraps across visible-area edges instead of clamping.
module sprite_game_controller
  import game_pkg::*;
#(
  parameter int N_OBS     = 4,
  parameter int P_HALF    = 30,
  parameter int OBS_HW    = 60,
  parameter int OBS_HH    = 10,
  parameter int P_STEP    = 2,
  parameter int OBS_STEP  = 1,
  parameter int X_MIN     = DEF_X_MIN,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_MIN     = DEF_Y_MIN,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int LIVES     = 3,
  parameter int INV_TICKS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [2:0]  lives,
  output logic        game_over
);

  localparam int INV_W =
    ($clog2(INV_TICKS) < 3) ? 3 : $clog2(INV_TICKS);
  localparam logic [INV_W-1:0] INV_LAST =
    INV_W'(INV_TICKS - 1);

  localparam logic signed [10:0] S_STEP = 11'(P_STEP);
  localparam logic signed [10:0] S_PH   = 11'(P_HALF);
`ifdef WRAP_EN
  localparam logic signed [10:0] S_XLO = 11'(X_MIN);
  localparam logic signed [10:0] S_XHI = 11'(X_MAX);
  localparam logic signed [10:0] S_YLO = 11'(Y_MIN);
  localparam logic signed [10:0] S_YHI = 11'(Y_MAX);
`else
  localparam logic signed [10:0] S_XLO = 11'(X_MIN + P_HALF);
  localparam logic signed [10:0] S_XHI = 11'(X_MAX - P_HALF);
  localparam logic signed [10:0] S_YLO = 11'(Y_MIN + P_HALF);
  localparam logic signed [10:0] S_YHI = 11'(Y_MAX - P_HALF);
`endif

  state_e           state_q, state_d;
  logic [2:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_q, inv_d;
  logic [9:0]       px_q, px_d;
  logic [9:0]       py_q, py_d;
  logic [11:0]      bg_q, bg_d;

  logic [N_OBS-1:0] obs_fill;
  logic [N_OBS-1:0] obs_hit;
  logic             adv;
  logic             p_fill;
  logic             p_show;

  assign adv = tick && (state_q != ST_OVER);

  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    obstacle_lane #(
      .X_POS    (X_MIN + ((i + 1) * (X_MAX - X_MIN)) / (N_OBS + 1)),
      .Y_INIT   (Y_MIN + (i * (Y_MAX - Y_MIN)) / N_OBS),
      .OBS_HW   (OBS_HW),
      .OBS_HH   (OBS_HH),
      .OBS_STEP (OBS_STEP),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX),
      .P_HALF   (P_HALF)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .h_count (hCount),
      .v_count (vCount),
      .p_x     (px_q),
      .p_y     (py_q),
      .fill    (obs_fill[i]),
      .hit     (obs_hit[i])
    );
  end

  // Player motion: one axis per tick, right > left > up > down.
  always_comb begin
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    nx   = s11(px_q);
    ny   = s11(py_q);
    px_d = px_q;
    py_d = py_q;
    if (adv) begin
      if (right)     nx = nx + S_STEP;
      else if (left) nx = nx - S_STEP;
      else if (up)   ny = ny - S_STEP;
      else if (down) ny = ny + S_STEP;
`ifdef WRAP_EN
      if (nx > S_XHI)      nx = S_XLO;
      else if (nx < S_XLO) nx = S_XHI;
      if (ny > S_YHI)      ny = S_YLO;
      else if (ny < S_YLO) ny = S_YHI;
`else
      if (nx > S_XHI)      nx = S_XHI;
      else if (nx < S_XLO) nx = S_XLO;
      if (ny > S_YHI)      ny = S_YHI;
      else if (ny < S_YLO) ny = S_YLO;
`endif
      px_d = nx[9:0];
      py_d = ny[9:0];
    end
  end

  // Background remembers the last button seen on a live tick.
  always_comb begin
    bg_d = bg_q;
    if (adv) begin
      if (right)     bg_d = C_RIGHT;
      else if (left) bg_d = C_LEFT;
      else if (up)   bg_d = C_UP;
      else if (down) bg_d = C_DOWN;
    end
  end

  // Lives FSM: collision costs a life, HIT masks collisions for a while.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    inv_d   = inv_q;
    if (tick) begin
      unique case (state_q)
        ST_PLAY: begin
          if (|obs_hit) begin
            if (lives_q > 3'd1) begin
              state_d = ST_HIT;
              lives_d = lives_q - 3'd1;
              inv_d   = '0;
            end else begin
              state_d = ST_OVER;
              lives_d = 3'd0;
            end
          end
        end
        ST_HIT: begin
          if (inv_q == INV_LAST) begin
            state_d = ST_PLAY;
            inv_d   = '0;
          end else begin
            inv_d = inv_q + 1'b1;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PLAY;
      lives_q <= 3'(LIVES);
      inv_q   <= '0;
      px_q    <= 10'(P_X0);
      py_q    <= 10'(P_Y0);
      bg_q    <= C_RESET;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      bg_q    <= bg_d;
    end
  end

  assign p_fill = in_box(s11(hCount), s11(px_q), S_PH)
               && in_box(s11(vCount), s11(py_q), S_PH);
  assign p_show = (state_q != ST_HIT) || inv_q[2];

  // Pixel colour: blanking, player, obstacles, background.
  always_comb begin
    rgb = C_BLACK;
    if (!bright)               rgb = C_BLACK;
    else if (p_fill && p_show) rgb = C_PLAYER;
    else if (|obs_fill)        rgb = C_OBS;
    else if (state_q == ST_OVER) rgb = C_OVER;
    else                       rgb = bg_q;
  end

  assign lives     = lives_q;
  assign game_over = (state_q == ST_OVER);

endmodule
